// File: rtl/stack_engine_if.sv
// Command channel from the decode stage into the stack sequencer.
// The decoder drives the request and the engine returns ready.
interface stack_engine_if #(
    parameter int NREG   = 8,
    parameter int ADDR_W = 16
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [NREG:0]     cmd_rlist;
    logic [ADDR_W-1:0] cmd_imm;

    modport master (output cmd_valid, cmd_op, cmd_rlist, cmd_imm, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_rlist, cmd_imm, output cmd_ready);
endinterface

// File: rtl/stack_engine.sv
// Multi-register stack sequencer: PUSH/POP move one word per cycle between
// the register file and data memory; ADJ/SETSP update SP directly.
module stack_engine #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                NREG     = 8,
    parameter logic [ADDR_W-1:0] STACK_LO = 'h0080,
    parameter logic [ADDR_W-1:0] SP_INIT  = 'h0100
) (
    input  logic                    clk,
    input  logic                    reset,
    stack_engine_if.slave           bus,
    output logic [$clog2(NREG)-1:0] rf_raddr,
    input  logic [DATA_W-1:0]       rf_rdata,
    input  logic [DATA_W-1:0]       lr_in,
    output logic                    rf_wr,
    output logic [$clog2(NREG)-1:0] rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic                    pc_wr,
    output logic [DATA_W-1:0]       pc_wdata,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [ADDR_W-1:0]       sp,
    output logic                    busy,
    output logic                    done,
    output logic                    fault,
    output logic [1:0]              fault_code
);
    localparam int RA_W  = $clog2(NREG);
    localparam int IDX_W = $clog2(NREG + 1);
    localparam int CNT_W = $clog2(NREG + 2);
    localparam logic [IDX_W-1:0] SPECIAL = IDX_W'(NREG);  // LR on PUSH, PC on POP

    typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;
    typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_ADJ = 2'b10, OP_SETSP = 2'b11} op_t;

    state_t            state;
    logic [NREG:0]     rem;
    logic [IDX_W-1:0]  cur;
    logic              is_pop;
    logic [ADDR_W-1:0] pending_sp;

    function automatic logic [IDX_W-1:0] lowest(input logic [NREG:0] v);
        lowest = '0;
        for (int i = NREG; i >= 0; i--)
            if (v[i]) lowest = IDX_W'(i);
    endfunction

    function automatic logic [CNT_W-1:0] count_ones(input logic [NREG:0] v);
        count_ones = '0;
        for (int i = 0; i <= NREG; i++)
            count_ones = count_ones + CNT_W'(v[i]);
    endfunction

    function automatic logic in_range(input logic [ADDR_W:0] x);
        in_range = !x[ADDR_W] && x[ADDR_W-1:0] >= STACK_LO && x[ADDR_W-1:0] <= SP_INIT;
    endfunction

    op_t               op;
    logic [CNT_W-1:0]  n;
    logic [ADDR_W:0]   sp_x, push_sp, pop_sp, adj_sp, set_sp, target;
    logic [1:0]        code_nx;
    logic [IDX_W-1:0]  first, nxt;

    // NOTE: always_comb with a default for every output first so no latch can be inferred.
    always_comb begin
        op      = op_t'(bus.cmd_op);
        n       = count_ones(bus.cmd_rlist);
        sp_x    = {1'b0, sp};
        push_sp = sp_x - (ADDR_W+1)'(n);
        pop_sp  = sp_x + (ADDR_W+1)'(n);
        adj_sp  = sp_x + {bus.cmd_imm[ADDR_W-1], bus.cmd_imm};
        set_sp  = {1'b0, bus.cmd_imm};
        first   = lowest(bus.cmd_rlist);
        nxt     = lowest(rem);
        target  = sp_x;
        code_nx = 2'b00;
        case (op)
            OP_PUSH: begin
                target = push_sp;
                if (push_sp[ADDR_W] || push_sp[ADDR_W-1:0] < STACK_LO) code_nx = 2'b01;
            end
            OP_POP: begin
                target = pop_sp;
                if (pop_sp > {1'b0, SP_INIT}) code_nx = 2'b10;
            end
            OP_ADJ: begin
                target = adj_sp;
                if (!in_range(adj_sp)) code_nx = 2'b11;
            end
            default: begin
                target = set_sp;
                if (!in_range(set_sp)) code_nx = 2'b11;
            end
        endcase
    end

    assign bus.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign mem_wdata     = mem_wr ? ((cur == SPECIAL) ? lr_in : rf_rdata) : '0;
    assign rf_wdata      = rf_wr ? mem_rdata : '0;
    assign pc_wdata      = pc_wr ? mem_rdata : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sp         <= SP_INIT;
            pending_sp <= SP_INIT;
            rem        <= '0;
            cur        <= '0;
            is_pop     <= 1'b0;
            rf_raddr   <= '0;
            rf_waddr   <= '0;
            rf_wr      <= 1'b0;
            pc_wr      <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            done  <= 1'b0;
            rf_wr <= 1'b0;
            pc_wr <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    fault      <= (code_nx != 2'b00);
                    fault_code <= code_nx;
                    pending_sp <= target[ADDR_W-1:0];
                    is_pop     <= (op == OP_POP);
                    if (code_nx != 2'b00 || op == OP_ADJ || op == OP_SETSP || n == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                        if (code_nx == 2'b00) sp <= target[ADDR_W-1:0];
                    end else begin
                        state    <= XFER;
                        cur      <= first;
                        rem      <= bus.cmd_rlist & ~((NREG+1)'(1) << first);
                        rf_raddr <= RA_W'(first);
                        mem_addr <= (op == OP_POP) ? sp : push_sp[ADDR_W-1:0];
                        mem_wr   <= (op == OP_PUSH);
                        mem_rd   <= (op == OP_POP);
                    end
                end
                XFER: begin
                    // POP data returns one cycle after the read, so writeback trails by a slot.
                    if (is_pop) begin
                        rf_wr    <= (cur != SPECIAL);
                        pc_wr    <= (cur == SPECIAL);
                        rf_waddr <= RA_W'(cur);
                    end
                    if (rem != '0) begin
                        cur      <= nxt;
                        rem      <= rem & ~((NREG+1)'(1) << nxt);
                        rf_raddr <= RA_W'(nxt);
                        mem_addr <= mem_addr + 1'b1;
                    end else begin
                        state    <= FIN;
                        done     <= 1'b1;
                        sp       <= pending_sp;
                        mem_wr   <= 1'b0;
                        mem_rd   <= 1'b0;
                        mem_addr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
